// File: rtl/dmem_arbiter.sv
// Two-port line arbiter in front of the shared 256-bit data memory.
// Serves one I-cache or D-cache line transaction at a time through an IDLE/ISSUE/WAIT/RESP handshake.
module dmem_arbiter #(
  parameter logic FIXED_PRIO = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         p0_req_i,
  input  logic         p0_write_i,
  input  logic [31:0]  p0_addr_i,
  input  logic [255:0] p0_data_i,
  output logic         p0_ack_o,
  output logic [255:0] p0_data_o,
  input  logic         p1_req_i,
  input  logic         p1_write_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [255:0] p1_data_i,
  output logic         p1_ack_o,
  output logic [255:0] p1_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic         mem_ack_i,
  input  logic [255:0] mem_data_i,
  output logic         busy_o,
  output logic         grant_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic         write_q, write_d;
  logic [31:0]  addr_q, addr_d;
  logic [255:0] data_q, data_d;
  logic         grant_q, grant_d;
  logic         last_grant_q, last_grant_d;
  logic         enable_q, enable_d;
  logic         ack0_q, ack0_d;
  logic         ack1_q, ack1_d;
  logic         winner_s;
  logic         read_resp_s;

  // With both ports requesting, round-robin favours the port that did not win last time.
  function automatic logic pick_port(input logic r0, input logic r1, input logic last, input logic fixed);
    logic win;
    win = 1'b0;
    if (r0 && r1) begin
      if (fixed) begin
        win = 1'b0;
      end else begin
        win = ~last;
      end
    end else if (r1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

  assign winner_s = pick_port(p0_req_i, p1_req_i, last_grant_q, FIXED_PRIO);

  // Next-state and holding-register update for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    data_d       = data_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    enable_d     = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (p0_req_i || p1_req_i) begin
          grant_d  = winner_s;
          write_d  = winner_s ? p1_write_i : p0_write_i;
          addr_d   = winner_s ? p1_addr_i  : p0_addr_i;
          data_d   = winner_s ? p1_data_i  : p0_data_i;
          enable_d = 1'b1;
          state_d  = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and holding registers; reset abandons any in-flight transaction without an ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      addr_q       <= 32'd0;
      data_q       <= 256'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      enable_q     <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      enable_q     <= enable_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
    end
  end

  // The read line arrives in the RESP cycle itself, so it is steered straight through.
  assign read_resp_s  = (state_q == S_RESP) && !write_q;
  assign p0_data_o    = (read_resp_s && !grant_q) ? mem_data_i : 256'd0;
  assign p1_data_o    = (read_resp_s &&  grant_q) ? mem_data_i : 256'd0;
  assign p0_ack_o     = ack0_q;
  assign p1_ack_o     = ack1_q;
  assign mem_enable_o = enable_q;
  assign mem_write_o  = write_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;
  assign busy_o       = (state_q != S_IDLE);
  assign grant_o      = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: instance 0 round-robin, instance 1 fixed priority,
// each behind a 10-cycle line memory model.
module tb_dmem_arbiter;

  typedef struct {
    int           d;
    int           p;
    logic [31:0]  addr;
    logic         w;
    logic [255:0] data;
  } sb_t;

  typedef struct {
    int d;
    int p;
    int c;
  } log_t;

  logic clk;
  logic rst;
  logic [1:0][1:0]        req, wr, ack;
  logic [1:0][1:0][31:0]  addr;
  logic [1:0][1:0][255:0] wdat, rdat;
  logic [1:0]             mem_en, mem_wr, mem_ack, busy, grant;
  logic [1:0][31:0]       mem_addr;
  logic [1:0][255:0]      mem_wdat, mem_rdat;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int en_cnt[2];
  int en_last[2];
  int mon_idx;
  sb_t  sb[$];
  log_t ack_log[$];
  logic [255:0] gold [2][16];

  localparam logic [255:0] PAT_A = {8{32'hA5A5_0002}};
  localparam logic [255:0] PAT_B = {8{32'hB0B0_1234}};
  localparam logic [255:0] PAT_C = {8{32'hC3C3_5678}};
  localparam logic [255:0] PAT_D = {8{32'hD00D_9ABC}};
  localparam logic [255:0] PAT_E = {8{32'hEEEE_0F0F}};

  function automatic logic [255:0] line_init(input int i);
    if (i == 2) return PAT_A;
    return {8{32'h1000_0000 + 32'(i)}};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [3:0]   cnt;
    logic [3:0]   la;
    logic         lw;
    logic [255:0] ld;
    logic [255:0] rd;
    logic         mack;
    logic [255:0] mm [16];

    dmem_arbiter #(.FIXED_PRIO(g == 1)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .p0_req_i(req[g][0]), .p0_write_i(wr[g][0]), .p0_addr_i(addr[g][0]), .p0_data_i(wdat[g][0]),
      .p0_ack_o(ack[g][0]), .p0_data_o(rdat[g][0]),
      .p1_req_i(req[g][1]), .p1_write_i(wr[g][1]), .p1_addr_i(addr[g][1]), .p1_data_i(wdat[g][1]),
      .p1_ack_o(ack[g][1]), .p1_data_o(rdat[g][1]),
      .mem_enable_o(mem_en[g]), .mem_write_o(mem_wr[g]), .mem_addr_o(mem_addr[g]),
      .mem_data_o(mem_wdat[g]), .mem_ack_i(mem_ack[g]), .mem_data_i(mem_rdat[g]),
      .busy_o(busy[g]), .grant_o(grant[g])
    );

    initial for (int i = 0; i < 16; i++) mm[i] = line_init(i);

    // Memory model: ack 10 cycles after the enable is seen, read line valid the cycle after ack.
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt  <= 4'd0;
        mack <= 1'b0;
        rd   <= 256'd0;
      end else begin
        mack <= 1'b0;
        if (mem_en[g]) begin
          cnt <= 4'd9;
          la  <= mem_addr[g][8:5];
          lw  <= mem_wr[g];
          ld  <= mem_wdat[g];
        end else if (cnt == 4'd1) begin
          mack <= 1'b1;
          cnt  <= 4'd0;
        end else if (cnt > 4'd1) begin
          cnt <= cnt - 4'd1;
        end
        if (mack) begin
          if (lw) mm[la] <= ld;
          else    rd     <= mm[la];
        end
      end
    end

    assign mem_ack[g]  = mack;
    assign mem_rdat[g] = rd;
  end

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input int d);
    check_eq("rst_busy", busy[d], 1'b0);
    check_eq("rst_mem_en", mem_en[d], 1'b0);
    check_eq("rst_mem_wr", mem_wr[d], 1'b0);
    check_eq("rst_mem_addr", mem_addr[d], 32'd0);
    check_eq("rst_mem_data", mem_wdat[d], 256'd0);
    check_eq("rst_ack0", ack[d][0], 1'b0);
    check_eq("rst_ack1", ack[d][1], 1'b0);
    check_eq("rst_data0", rdat[d][0], 256'd0);
    check_eq("rst_data1", rdat[d][1], 256'd0);
    check_eq("rst_grant", grant[d], 1'b0);
  endtask

  // One transaction on port p of instance d; call at posedge+1. exp_lat 0 means contention, no latency check.
  task automatic txn(input int d, input int p, input logic w, input logic [31:0] a,
                     input logic [255:0] wd, input int exp_lat);
    sb_t e;
    int  t0;
    bit  got;
    e.d = d; e.p = p; e.addr = a; e.w = w;
    e.data = w ? 256'd0 : gold[d][a[8:5]];
    if (w) gold[d][a[8:5]] = wd;
    sb.push_back(e);
    wr[d][p] = w; addr[d][p] = a; wdat[d][p] = wd; req[d][p] = 1'b1;
    t0 = cyc;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (ack[d][p]) got = 1'b1;
    end
    if (!got) check_eq("ack_timeout", 1'b0, 1'b1);
    else if (exp_lat > 0) check_eq("latency", cyc - t0, exp_lat);
    @(posedge clk); #1;
    req[d][p] = 1'b0;
  endtask

  task automatic check_order(input string tag, input int d, input int exp_p[$]);
    log_t l[$];
    foreach (ack_log[i]) if (ack_log[i].d == d) l.push_back(ack_log[i]);
    check_eq({tag, "_count"}, l.size(), exp_p.size());
    for (int i = 0; i < l.size() && i < exp_p.size(); i++) begin
      check_eq({tag, "_port"}, l[i].p, exp_p[i]);
      if (i > 0) check_eq({tag, "_gap"}, l[i].c - l[i-1].c, 13);
    end
  endtask

  // Response monitor: every ack is matched against the oldest scoreboard entry for that port.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_en[d]) begin
        en_cnt[d]++;
        en_last[d] = cyc;
      end
      for (int p = 0; p < 2; p++) begin
        if (ack[d][p]) begin
          ack_log.push_back('{d: d, p: p, c: cyc});
          check_eq("other_ack", ack[d][1-p], 1'b0);
          check_eq("other_data", rdat[d][1-p], 256'd0);
          check_eq("grant", grant[d], p);
          mon_idx = -1;
          for (int k = 0; k < sb.size(); k++)
            if (mon_idx < 0 && sb[k].d == d && sb[k].p == p) mon_idx = k;
          if (mon_idx < 0) begin
            check_eq("spurious_ack", 1'b1, 1'b0);
          end else begin
            check_eq("rdata", rdat[d][p], sb[mon_idx].data);
            check_eq("resp_mem_addr", mem_addr[d], sb[mon_idx].addr);
            check_eq("resp_mem_wr", mem_wr[d], sb[mon_idx].w);
            sb.delete(mon_idx);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      en_cnt[d] = 0;
      en_last[d] = -1;
      for (int i = 0; i < 16; i++) gold[d][i] = line_init(i);
    end
    rst = 1'b0;
    req = '0; wr = '0; addr = '0; wdat = '0;

    // Reset values
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single read of line 2 on port 0, request in cycle 5
    ack_log.delete();
    txn(0, 0, 1'b0, 32'h0000_0040, 256'd0, 12);
    check_eq("t1_en_count", en_cnt[0], 1);
    check_eq("t1_en_cycle", en_last[0], 6);
    check_eq("t1_ack_cycle", ack_log[0].c, 17);
    check_eq("t1_ack_total", ack_log.size(), 1);

    // Write then read back on port 1
    txn(0, 1, 1'b1, 32'h0000_0020, PAT_B, 12);
    txn(0, 1, 1'b0, 32'h0000_0020, 256'd0, 12);

    // Round-robin ties: both ports hold requests
    ack_log.delete();
    fork
      begin
        txn(0, 0, 1'b0, 32'h0000_0080, 256'd0, 0);
        txn(0, 0, 1'b0, 32'h0000_00A0, 256'd0, 0);
      end
      begin
        txn(0, 1, 1'b0, 32'h0000_00C0, 256'd0, 0);
        txn(0, 1, 1'b0, 32'h0000_00E0, 256'd0, 0);
      end
    join
    check_order("rr", 0, '{0, 1, 0, 1});

    // Port 1 shows up mid-transaction with a moving address and line
    ack_log.delete();
    fork
      txn(0, 0, 1'b1, 32'h0000_01C0, PAT_D, 12);
      begin
        repeat (5) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
          #1;
          req[0][1]  = 1'b1;
          wr[0][1]   = 1'($urandom_range(0, 1));
          addr[0][1] = $urandom & 32'hFFFF_FFE0;
          wdat[0][1] = {8{$urandom}};
          @(negedge clk);
          check_eq("hold_addr", mem_addr[0], 32'h0000_01C0);
          check_eq("hold_data", mem_wdat[0], PAT_D);
          check_eq("hold_wr", mem_wr[0], 1'b1);
          check_eq("hold_en", mem_en[0], 1'b0);
          @(posedge clk);
        end
        #1;
        txn(0, 1, 1'b0, 32'h0000_0060, 256'd0, 0);
      end
    join
    check_order("late", 0, '{0, 1});
    txn(0, 0, 1'b0, 32'h0000_01C0, 256'd0, 12);

    // Reset pulse while a port 1 write is waiting on memory
    ack_log.delete();
    wr[0][1] = 1'b1; addr[0][1] = 32'h0000_01E0; wdat[0][1] = PAT_E; req[0][1] = 1'b1;
    @(posedge clk); #1;
    req[0][1] = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_eq("pre_rst_busy", busy[0], 1'b1);
    check_eq("pre_rst_grant", grant[0], 1'b1);
    check_eq("pre_rst_addr", mem_addr[0], 32'h0000_01E0);
    rst = 1'b0;
    #1;
    check_reset(0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check_eq("rst_no_ack", ack_log.size(), 0);
    fork
      txn(0, 0, 1'b0, 32'h0000_01E0, 256'd0, 12);
      txn(0, 1, 1'b0, 32'h0000_0000, 256'd0, 0);
    join
    check_order("post_rst", 0, '{0, 1});

    // Fixed priority: port 0 keeps re-requesting, port 1 gets in only on a one-cycle gap
    ack_log.delete();
    fork
      begin
        txn(1, 0, 1'b0, 32'h0000_0100, 256'd0, 0);
        txn(1, 0, 1'b1, 32'h0000_0120, PAT_C, 0);
        txn(1, 0, 1'b0, 32'h0000_0140, 256'd0, 0);
        @(posedge clk); #1;
        txn(1, 0, 1'b0, 32'h0000_0120, 256'd0, 0);
      end
      txn(1, 1, 1'b0, 32'h0000_0180, 256'd0, 0);
    join
    check_order("fixed", 1, '{0, 0, 0, 1, 0});
    check_eq("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single 256-bit-line data memory between the instruction-cache and data-cache refill/write-back controllers. It accepts one line transaction at a time from either port, registers the address, line and direction, and drives the memory's enable/write/ack handshake. It returns the memory's ack and read line to the winning port only. It sits between the two cache controllers and the data memory, with the memory's fixed 10-cycle access latency hidden behind a per-port request/ack handshake.

## Interface
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins ties
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- p0_req_i  in  1  port 0 (I-cache) request; held until p0_ack_o
- p0_write_i  in  1  port 0 direction, 1 = write line
- p0_addr_i  in  32  port 0 byte address (line-aligned; bits [4:0] ignored by memory)
- p0_data_i  in  256  port 0 write line
- p0_ack_o  out  1  port 0 completion pulse, one cycle
- p0_data_o  out  256  port 0 read line, valid only with p0_ack_o on reads
- p1_req_i, p1_write_i, p1_addr_i, p1_data_i, p1_ack_o, p1_data_o: same as port 0, for the D-cache
- mem_enable_o  out  1  memory start strobe
- mem_write_o  out  1  memory direction
- mem_addr_o  out  32  memory address
- mem_data_o  out  256  memory write line
- mem_ack_i  in  1  memory completion, one cycle
- mem_data_i  in  256  memory read line, valid the cycle after mem_ack_i
- busy_o  out  1  transaction in flight (state != IDLE)
- grant_o  out  1  port owning current/last transaction (0 or 1)

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_i is high, pick the winner and latch its write/addr/data into holding registers and grant_o. Then go to ISSUE. Otherwise stay.
- Arbitration, FIXED_PRIO=0: single requester wins. When both request, the port opposite last_grant wins. last_grant resets to 1, so port 0 wins the first tie.
- Arbitration, FIXED_PRIO=1: port 0 wins any tie.
- ISSUE: mem_enable_o=1 for exactly this cycle. Then go to WAIT.
- WAIT: mem_enable_o=0. On mem_ack_i=1, go to RESP.
- RESP: granted port's ack_o=1. For reads, that port's data_o=mem_data_i. Update last_grant. Then go to IDLE.
- mem_write_o, mem_addr_o and mem_data_o are driven from the holding registers. They are stable from ISSUE through RESP and are never changed mid-transaction.
- data_o is 0 on both ports except the granted port in RESP of a read. ack_o is 0 on the non-granted port at all times.
- Requester rule: deassert req the cycle after ack. A req still high in the following IDLE is treated as a new transaction.
- Request inputs are not sampled outside IDLE. A loser keeps its req high and is served next.
- mem_ack_i outside WAIT is ignored.

## Timing
- Reset values: state IDLE, mem_enable_o 0, mem_write_o 0, mem_addr_o 0, mem_data_o 0, both ack_o 0, both data_o 0, busy_o 0, grant_o 0, last_grant 1.
- Reset is asynchronous and may occur in any state. The arbiter returns to IDLE immediately. No ack is issued for the aborted transaction. The memory shares rst_i, so no cleanup handshake is needed.
- Latency, with req seen in IDLE at cycle T:
  - ISSUE at T+1.
  - Memory starts counting at T+2.
  - mem_ack_i at T+11.
  - RESP/ack_o at T+12.
  - IDLE at T+13.
- Back-to-back throughput: one line per 13 cycles.
- A new requester arriving during ISSUE/WAIT/RESP waits until the next IDLE cycle.

## Test plan
- Single read, port 0, addr 0x40 (memory line 2 preloaded with pattern A), req at cycle 5:
  - mem_enable_o high only at cycle 6.
  - p0_ack_o at cycle 17 with p0_data_o = A.
  - p1_ack_o stays 0.
- Write then read, port 1, addr 0x20, line B:
  - p1_ack_o 12 cycles after req, with p1_data_o = 0.
  - Subsequent read of 0x20 returns B.
- Simultaneous requests, FIXED_PRIO=0, both held:
  - Grant order is 0, 1, 0, 1.
  - Each ack is 13 cycles apart.
  - The non-granted data_o is always 0.
- Simultaneous requests, FIXED_PRIO=1, port 0 re-requesting continuously:
  - Port 0 is served every transaction.
  - Port 1 is served only when port 0 idles one cycle.
- Port 1 req arrives during port 0 WAIT with changing addr/data:
  - mem_addr_o and mem_data_o remain port 0 values until RESP.
  - Port 1 is issued from the next IDLE.
- rst_i pulsed low in WAIT:
  - All outputs go to reset values asynchronously.
  - No ack is issued.
  - After release, a new request completes in 12 cycles.
